// File: rtl/div_unit_if.sv
// Pipeline EX <-> divider handshake: operands and control in, stall request and hi/lo result out.
// The master modport is the pipeline side and the slave modport is the divider side.
interface div_unit_if;
  logic        start;
  logic        signed_op;
  logic [31:0] opr1;
  logic [31:0] opr2;
  logic        advance;
  logic        flush;
  logic        stallreq;
  logic        ready;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, signed_op, opr1, opr2, advance, flush,
    input  stallreq, ready, hi, lo
  );

  modport slave (
    input  start, signed_op, opr1, opr2, advance, flush,
    output stallreq, ready, hi, lo
  );
endinterface

// File: rtl/div_unit.sv
// 32-bit restoring divider (DIV/DIVU): result ready 33 cycles after start, held in DONE until advance; stalls EX meanwhile.
// Define DIV_ZERO_FAST_EN to finish a zero-divisor request in one cycle with hi=lo=0.
module div_unit (
  input logic       clk,
  input logic       resetn,
  div_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state;
  logic [5:0]  cnt;
  logic [63:0] rem;
  logic [31:0] dvs;
  logic        neg_q;
  logic        neg_r;

  logic        sgn1;
  logic        sgn2;
  logic [31:0] abs1;
  logic [31:0] abs2;
  logic [32:0] part;
  logic        fits;
  logic [31:0] sub;
  logic [63:0] rem_nxt;
  logic [31:0] q_fin;
  logic [31:0] r_fin;

  always_comb begin
    sgn1 = bus.signed_op & bus.opr1[31];
    sgn2 = bus.signed_op & bus.opr2[31];
    abs1 = sgn1 ? (~bus.opr1 + 32'd1) : bus.opr1;
    abs2 = sgn2 ? (~bus.opr2 + 32'd1) : bus.opr2;
    // Shifted partial remainder needs 33 bits when the divisor is >= 2^31
    part = rem[63:31];
    fits = part >= {1'b0, dvs};
    sub  = part[31:0] - dvs;
    rem_nxt = fits ? {sub, rem[30:0], 1'b1} : {rem[62:0], 1'b0};
    q_fin = neg_q ? (~rem_nxt[31:0] + 32'd1) : rem_nxt[31:0];
    r_fin = neg_r ? (~rem_nxt[63:32] + 32'd1) : rem_nxt[63:32];
  end

  assign bus.stallreq = resetn & ~bus.flush &
                        (((state == IDLE) & bus.start) | (state == CALC));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      cnt       <= 6'd0;
      rem       <= 64'd0;
      dvs       <= 32'd0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      bus.ready <= 1'b0;
      bus.hi    <= 32'd0;
      bus.lo    <= 32'd0;
    end else if (bus.flush) begin
      state     <= IDLE;
      bus.ready <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            rem   <= {32'd0, abs1};
            dvs   <= abs2;
            neg_q <= sgn1 ^ sgn2;
            neg_r <= sgn1;
            cnt   <= 6'd0;
`ifdef DIV_ZERO_FAST_EN
            if (bus.opr2 == 32'd0) begin
              state     <= DONE;
              bus.ready <= 1'b1;
              bus.hi    <= 32'd0;
              bus.lo    <= 32'd0;
            end else begin
              state <= CALC;
            end
`else
            state <= CALC;
`endif
          end
        end
        CALC: begin
          rem <= rem_nxt;
          cnt <= cnt + 6'd1;
          if (cnt == 6'd31) begin
            state     <= DONE;
            bus.ready <= 1'b1;
            bus.hi    <= r_fin;
            bus.lo    <= q_fin;
          end
        end
        DONE: begin
          if (bus.advance) begin
            state     <= IDLE;
            bus.ready <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
